// File: rtl/jtag_tap_responder.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_responder
// Purpose  : IEEE 1149.1 TAP controller with IDCODE, BYPASS and one 32-bit user
//            data register. JTAG pins are oversampled on the system clock.
// Config   : define JTAG_TAP_TRST_EN to let jtag_trst_ni force Test-Logic-Reset
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_responder #(
  parameter logic [31:0] JTAG_ID = 32'h04F5484D,  // bit 0 must be 1
  parameter logic [4:0]  USER_IR = 5'h10
) (
  input  logic        clock,
  input  logic        reset_i,
  input  logic        jtag_tck_i,
  input  logic        jtag_tms_i,
  input  logic        jtag_tdi_i,
  input  logic        jtag_trst_ni,
  output logic        jtag_tdo_o,
  output logic        jtag_tdo_oe_o,
  output logic [4:0]  ir_o,
  output logic        dr_capture_o,
  input  logic [31:0] dr_rdata_i,
  output logic        dr_update_o,
  output logic [31:0] dr_wdata_o
);

  localparam logic [3:0] TLR     = 4'd0;
  localparam logic [3:0] RTI     = 4'd1;
  localparam logic [3:0] SEL_DR  = 4'd2;
  localparam logic [3:0] CAP_DR  = 4'd3;
  localparam logic [3:0] SH_DR   = 4'd4;
  localparam logic [3:0] EX1_DR  = 4'd5;
  localparam logic [3:0] PAU_DR  = 4'd6;
  localparam logic [3:0] EX2_DR  = 4'd7;
  localparam logic [3:0] UPD_DR  = 4'd8;
  localparam logic [3:0] SEL_IR  = 4'd9;
  localparam logic [3:0] CAP_IR  = 4'd10;
  localparam logic [3:0] SH_IR   = 4'd11;
  localparam logic [3:0] EX1_IR  = 4'd12;
  localparam logic [3:0] PAU_IR  = 4'd13;
  localparam logic [3:0] EX2_IR  = 4'd14;
  localparam logic [3:0] UPD_IR  = 4'd15;

  localparam logic [4:0] IR_IDCODE  = 5'h01;
  localparam logic [4:0] IR_CAPTURE = 5'b00001;

  logic       tck_meta, tck_sync, tck_prev;
  logic       tms_meta, tms_sync;
  logic       tdi_meta, tdi_sync;
  logic       trst_meta, trst_sync;
  logic       trst_force;
  logic       tck_rise, tck_fall;
  logic [3:0] state, state_next;
  logic [4:0] ir, ir_sr;
  logic [31:0] dr_sr;
  logic       bypass_sr;
  logic       tdo;
  logic       sel_id, sel_user, ir_path;

  // Two-flop synchronizers plus a third TCK copy for edge detection
  always_ff @(posedge clock) begin
    if (reset_i) begin
      tck_meta  <= 1'b0; tck_sync  <= 1'b0; tck_prev <= 1'b0;
      tms_meta  <= 1'b1; tms_sync  <= 1'b1;
      tdi_meta  <= 1'b0; tdi_sync  <= 1'b0;
      trst_meta <= 1'b1; trst_sync <= 1'b1;
    end else begin
      tck_meta  <= jtag_tck_i;   tck_sync  <= tck_meta;  tck_prev <= tck_sync;
      tms_meta  <= jtag_tms_i;   tms_sync  <= tms_meta;
      tdi_meta  <= jtag_tdi_i;   tdi_sync  <= tdi_meta;
      trst_meta <= jtag_trst_ni; trst_sync <= trst_meta;
    end
  end

`ifdef JTAG_TAP_TRST_EN
  assign trst_force = ~trst_sync;
`else
  // TRST pin is synchronized but has no effect in this build
  assign trst_force = 1'b0;
  logic trst_unused;
  assign trst_unused = trst_sync;
`endif

  // Reset and TRST both swallow any TCK edge seen in the same cycle
  assign tck_rise = tck_sync & ~tck_prev & ~reset_i & ~trst_force;
  assign tck_fall = ~tck_sync & tck_prev & ~reset_i & ~trst_force;

  assign sel_id   = (ir == IR_IDCODE);
  assign sel_user = (ir == USER_IR);
  assign ir_path  = (state == CAP_IR) || (state == SH_IR) || (state == EX1_IR) ||
                    (state == PAU_IR) || (state == EX2_IR) || (state == UPD_IR);

  // TAP state register
  always_ff @(posedge clock) begin
    if (reset_i) state <= TLR;
    else         state <= state_next;
  end

  // TAP next-state: advances only on a detected TCK rise, driven by TMS
  always_comb begin
    state_next = state;
    if (trst_force) begin
      state_next = TLR;
    end else if (tck_rise) begin
      case (state)
        TLR:     state_next = tms_sync ? TLR    : RTI;
        RTI:     state_next = tms_sync ? SEL_DR : RTI;
        SEL_DR:  state_next = tms_sync ? SEL_IR : CAP_DR;
        CAP_DR:  state_next = tms_sync ? EX1_DR : SH_DR;
        SH_DR:   state_next = tms_sync ? EX1_DR : SH_DR;
        EX1_DR:  state_next = tms_sync ? UPD_DR : PAU_DR;
        PAU_DR:  state_next = tms_sync ? EX2_DR : PAU_DR;
        EX2_DR:  state_next = tms_sync ? UPD_DR : SH_DR;
        UPD_DR:  state_next = tms_sync ? SEL_DR : RTI;
        SEL_IR:  state_next = tms_sync ? TLR    : CAP_IR;
        CAP_IR:  state_next = tms_sync ? EX1_IR : SH_IR;
        SH_IR:   state_next = tms_sync ? EX1_IR : SH_IR;
        EX1_IR:  state_next = tms_sync ? UPD_IR : PAU_IR;
        PAU_IR:  state_next = tms_sync ? EX2_IR : PAU_IR;
        EX2_IR:  state_next = tms_sync ? UPD_IR : SH_IR;
        UPD_IR:  state_next = tms_sync ? SEL_DR : RTI;
        default: state_next = TLR;
      endcase
    end
  end

  // TAP outputs decoded from the current state and the TCK rise strobe
  always_comb begin
    jtag_tdo_oe_o = (state == SH_DR) || (state == SH_IR);
    dr_capture_o  = tck_rise && (state == CAP_DR) && sel_user;
    dr_update_o   = tck_rise && (state == UPD_DR) && sel_user;
  end

  // Instruction/data registers: capture, shift and update on TCK rise; TDO on fall
  always_ff @(posedge clock) begin
    if (reset_i) begin
      ir        <= IR_IDCODE;
      ir_sr     <= 5'd0;
      dr_sr     <= 32'd0;
      bypass_sr <= 1'b0;
      tdo       <= 1'b0;
    end else if (trst_force) begin
      ir        <= IR_IDCODE;
    end else begin
      if (state == TLR) ir <= IR_IDCODE;
      if (tck_rise) begin
        case (state)
          CAP_IR: ir_sr <= IR_CAPTURE;
          SH_IR:  ir_sr <= {tdi_sync, ir_sr[4:1]};
          UPD_IR: ir    <= ir_sr;
          CAP_DR: begin
            if (sel_id)        dr_sr     <= JTAG_ID;
            else if (sel_user) dr_sr     <= dr_rdata_i;
            else               bypass_sr <= 1'b0;
          end
          SH_DR: begin
            if (sel_id || sel_user) dr_sr     <= {tdi_sync, dr_sr[31:1]};
            else                    bypass_sr <= tdi_sync;
          end
          default: ;
        endcase
      end
      if (tck_fall) begin
        if (ir_path)                 tdo <= ir_sr[0];
        else if (sel_id || sel_user) tdo <= dr_sr[0];
        else                         tdo <= bypass_sr;
      end
    end
  end

  assign jtag_tdo_o = tdo;
  assign ir_o       = ir;
  assign dr_wdata_o = dr_sr;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_tap_responder
// Purpose  : directed self-checking bench for jtag_tap_responder; expected TDO
//            bits are queued as stimulus is driven and popped when sampled.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jtag_tap_responder;

  localparam logic [31:0] ID = 32'h04F5484D;

  logic        clock = 1'b0;
  logic        reset_i, tck, tms, tdi, trst_n;
  logic [31:0] dr_rdata;
  logic        tdo, tdo_oe, dr_capture, dr_update;
  logic [4:0]  ir;
  logic [31:0] dr_wdata;

  int total = 0, passed = 0, failed = 0;
  bit exp_q[$];
  int cap_cnt = 0, upd_cnt = 0, short_cnt = 0, run_len = 0;
  logic [31:0] last_wdata = 32'd0;
  logic tck_last = 1'b0;

  jtag_tap_responder dut (
    .clock(clock), .reset_i(reset_i),
    .jtag_tck_i(tck), .jtag_tms_i(tms), .jtag_tdi_i(tdi), .jtag_trst_ni(trst_n),
    .jtag_tdo_o(tdo), .jtag_tdo_oe_o(tdo_oe), .ir_o(ir),
    .dr_capture_o(dr_capture), .dr_rdata_i(dr_rdata),
    .dr_update_o(dr_update), .dr_wdata_o(dr_wdata)
  );

  always #5 clock = ~clock;

  // Pulse counters and update-data capture, sampled on the falling clock edge
  always @(negedge clock) begin
    if (dr_capture === 1'b1) cap_cnt <= cap_cnt + 1;
    if (dr_update === 1'b1) begin
      upd_cnt    <= upd_cnt + 1;
      last_wdata <= dr_wdata;
    end
  end

  // TCK phase-length monitor: any phase shorter than 2 clocks is below the /4 ratio
  always @(posedge clock) begin
    if (tck !== tck_last) begin
      if (run_len < 2) short_cnt <= short_cnt + 1;
      run_len  <= 1;
      tck_last <= tck;
    end else begin
      run_len <= run_len + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // One TCK period starting at a falling clock edge; optional TDO scoreboard check
  task automatic pulse(input logic t_ms, input logic t_di, input bit chk,
                       input int hi, input int lo, input string tag);
    bit e;
    tms = t_ms; tdi = t_di; tck = 1'b1;
    @(negedge clock);
    if (chk) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(tag, {31'd0, tdo}, {31'd0, e});
        check({tag, "_oe"}, {31'd0, tdo_oe}, 32'd1);
      end else begin
        total++; failed++;
        $error("FAIL %s observed=empty_queue expected=entry", tag);
      end
    end
    repeat (hi - 1) @(negedge clock);
    tck = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic tms_seq(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) pulse(bits[i], 1'b0, 1'b0, 2, 2, "");
  endtask

  // Shift n bits LSB first; last bit exits to Exit1 when ex is set
  task automatic shift(input int n, input logic [31:0] tdi_v, input logic [31:0] exp_v,
                       input bit ex, input string tag);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_v[i]);
    for (int i = 0; i < n; i++) pulse(ex && (i == n - 1), tdi_v[i], 1'b1, 2, 2, tag);
  endtask

  // From RTI: load an instruction and return to RTI
  task automatic load_ir(input logic [4:0] v);
    tms_seq(8'b0011, 4);                 // SelDR, SelIR, CapIR, ShIR
    shift(5, {27'd0, v}, 32'd1, 1'b1, "ir_capture");
    tms_seq(8'b01, 2);                   // UpdIR, RTI
  endtask

  initial begin
    int c0, u0, s0;
    reset_i = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1; dr_rdata = 32'd0;
    repeat (2) @(negedge clock);
    tck = 1'b1; tms = 1'b0;              // edge activity while reset is held
    repeat (2) @(negedge clock);
    tck = 1'b0;
    repeat (3) @(negedge clock);
    reset_i = 1'b0; tms = 1'b1;
    @(negedge clock);
    check("rst_ir", {27'd0, ir}, 32'h01);
    check("rst_tdo", {31'd0, tdo}, 32'd0);
    check("rst_oe", {31'd0, tdo_oe}, 32'd0);
    check("rst_cap", {31'd0, dr_capture}, 32'd0);
    check("rst_upd", {31'd0, dr_update}, 32'd0);

    // IDCODE read at clock/4
    s0 = short_cnt;
    tms_seq(8'h1F, 5);
    tms_seq(8'b0010, 4);                 // RTI, SelDR, CapDR, ShDR
    shift(32, 32'd0, ID, 1'b1, "idcode");
    tms_seq(8'b01, 2);
    check("idle_oe", {31'd0, tdo_oe}, 32'd0);
    check("idcode_no_pulses", cap_cnt + upd_cnt, 32'd0);
    check("div4_supported", short_cnt - s0, 32'd0);

    // User register round trip
    load_ir(5'h10);
    check("ir_user", {27'd0, ir}, 32'h10);
    dr_rdata = 32'hCAFEF00D; c0 = cap_cnt; u0 = upd_cnt;
    tms_seq(8'b001, 3);
    shift(32, 32'h12345678, 32'hCAFEF00D, 1'b1, "user_tdo");
    tms_seq(8'b01, 2);
    check("user_cap_cnt", cap_cnt - c0, 32'd1);
    check("user_upd_cnt", upd_cnt - u0, 32'd1);
    check("user_wdata", last_wdata, 32'h12345678);

    // BYPASS for 5'h1F and an unassigned code
    for (int k = 0; k < 2; k++) begin
      load_ir(k == 0 ? 5'h1F : 5'h07);
      c0 = cap_cnt; u0 = upd_cnt;
      tms_seq(8'b001, 3);
      shift(9, 32'h0A5, 32'h14A, 1'b1, "bypass_tdo");
      tms_seq(8'b01, 2);
      check("bypass_no_pulses", (cap_cnt - c0) + (upd_cnt - u0), 32'd0);
    end

    load_ir(5'h0A);
    check("ir_0a", {27'd0, ir}, 32'h0A);

    // reset_i in the middle of a user-register shift
    load_ir(5'h10);
    u0 = upd_cnt;
    tms_seq(8'b001, 3);
    shift(10, 32'h3FF, 32'h00D, 1'b0, "abort_tdo");
    reset_i = 1'b1;
    repeat (2) @(negedge clock);
    reset_i = 1'b0; tms = 1'b1;
    @(negedge clock);
    check("abort_ir", {27'd0, ir}, 32'h01);
    check("abort_oe", {31'd0, tdo_oe}, 32'd0);
    check("abort_no_update", upd_cnt - u0, 32'd0);
    tms_seq(8'b0010, 4);                 // must start from TLR
    shift(32, 32'd0, ID, 1'b1, "post_abort_idcode");
    tms_seq(8'b01, 2);

`ifdef JTAG_TAP_TRST_EN
    load_ir(5'h10);
    u0 = upd_cnt;
    tms_seq(8'b001, 3);
    shift(10, 32'h3FF, 32'h00D, 1'b0, "trst_tdo");
    trst_n = 1'b0;
    repeat (4) @(negedge clock);
    check("trst_ir", {27'd0, ir}, 32'h01);
    check("trst_no_update", upd_cnt - u0, 32'd0);
    trst_n = 1'b1;
    repeat (4) @(negedge clock);
    tms_seq(8'b0010, 4);
    shift(32, 32'd0, ID, 1'b1, "post_trst_idcode");
    tms_seq(8'b01, 2);
`endif

    // clock/3 TCK: a 1-clock phase must be flagged as unsupported
    s0 = short_cnt;
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, 1, 2, "");
    repeat (4) @(negedge clock);
    check("div3_flagged", {31'd0, (short_cnt > s0)}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
